// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver that buffers bytes in a show-ahead FIFO.
// Ports:
//   clk, resetn  : rising-edge clock and synchronous active-low reset
//   rx           : asynchronous serial input, idle high
//   rx_data      : FIFO head byte (show-ahead), valid when rx_avail=1
//   rx_avail     : FIFO holds at least one byte
//   rx_level     : number of bytes held, 0..DEPTH
//   pop          : consume the head byte this cycle (ignored when empty)
//   overrun      : sticky, a byte was dropped because the FIFO was full
//   frame_err    : sticky, a stop bit was sampled low
//   clr_err      : clears both sticky flags on the next edge
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH        = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   rx,
    output logic [7:0]             rx_data,
    output logic                   rx_avail,
    output logic [$clog2(DEPTH):0] rx_level,
    input  logic                   pop,
    output logic                   overrun,
    output logic                   frame_err,
    input  logic                   clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    shift;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    last_q;

    logic          bit_end;
    logic          push;
    logic          stop_err;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign bit_end  = (cnt == LAST);
    assign push     = (state == STOP) && bit_end && rx_s;
    assign stop_err = (state == STOP) && bit_end && !rx_s;

    assign rx_level = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (rx_level == FULL_LVL);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;

    assign rx_avail = !empty;
    // When empty the last consumed byte is held rather than stale memory.
    assign rx_data  = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shift <= '0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        bitn  <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        bitn  <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_q    <= 8'h00;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
                last_q <= mem[rd_ptr[AW-1:0]];
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (stop_err) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames on rx, scoreboard of expected bytes.
// A negedge monitor pops and compares whenever a pop consumes a byte.
module tb_uart_rx_fifo;

    localparam int C = 8;
    localparam int D = 4;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b0;
    logic       rx       = 1'b1;
    logic       clr_err  = 1'b0;
    logic       dir_pop  = 1'b0;
    logic       mon_pop  = 1'b0;
    logic       auto_pop = 1'b0;
    logic       pop;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic [2:0] rx_level;
    logic       overrun;
    logic       frame_err;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q [$];

    assign pop = mon_pop | dir_pop;

    uart_rx_fifo #(
        .CLKS_PER_BIT(C),
        .DEPTH       (D)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_level (rx_level),
        .pop      (pop),
        .overrun  (overrun),
        .frame_err(frame_err),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic       p;
        logic [7:0] exp_b;
        mon_pop = auto_pop && rx_avail;
        p = mon_pop | dir_pop;
        if (p && rx_avail) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL pop_extra: got %0h want none", rx_data);
            end else begin
                exp_b = q.pop_front();
                if (rx_data !== exp_b) begin
                    bad++;
                    $display("FAIL pop_data: got %0h want %0h",
                             rx_data, exp_b);
                end
            end
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (C) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        auto_pop = 1'b1;
        repeat (3 * D) @(posedge clk);
        #1;
        auto_pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_avail", rx_avail, 0);
        check("rst_level", rx_level, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ovr", overrun, 0);
        check("rst_ferr", frame_err, 0);
        resetn = 1'b1;
        idle(4);

        q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        idle(2);
        check("a5_avail", rx_avail, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_level", rx_level, 1);
        drain();
        check("a5_empty", rx_avail, 0);
        check("a5_hold", rx_data, 8'hA5);

        q.push_back(8'h00);
        q.push_back(8'hFF);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle(2);
        check("b2b_level", rx_level, 2);
        drain();
        check("b2b_drained", rx_level, 0);

        q.push_back(8'h11);
        q.push_back(8'h22);
        q.push_back(8'h33);
        q.push_back(8'h44);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        send(8'h55, 1'b1);
        idle(2);
        check("ovr_level", rx_level, 4);
        check("ovr_flag", overrun, 1);
        check("ovr_head", rx_data, 8'h11);
        check("ovr_ferr", frame_err, 0);
        pulse_clr();
        check("ovr_clr", overrun, 0);
        check("ovr_keep", rx_level, 4);

        // Stop sample lands 79 edges after the start bit begins.
        q.push_back(8'h66);
        fork
            send(8'h66, 1'b1);
            begin
                repeat (78) @(posedge clk);
                #1;
                dir_pop = 1'b1;
                @(posedge clk);
                #1;
                dir_pop = 1'b0;
            end
        join
        idle(2);
        check("pp_level", rx_level, 4);
        check("pp_ovr", overrun, 0);
        check("pp_head", rx_data, 8'h22);
        drain();
        check("pp_drained", rx_level, 0);

        send(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check("fe_flag", frame_err, 1);
        check("fe_level", rx_level, 0);
        check("fe_ovr", overrun, 0);
        idle(16);
        q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        idle(2);
        check("fe_next", rx_level, 1);
        check("fe_sticky", frame_err, 1);
        drain();
        pulse_clr();
        check("fe_clr", frame_err, 0);

        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(20);
        check("gl_avail", rx_avail, 0);
        check("gl_ferr", frame_err, 0);
        q.push_back(8'h96);
        send(8'h96, 1'b1);
        idle(2);
        check("gl_next", rx_level, 1);
        drain();
        check("sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
